// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   uart_state_t : serialiser FSM state encoding (IDLE/START/DATA/STOP)
//   DATA_BITS    : payload bits per frame
//   STOP_BITS    : stop bits per frame
//   bit_cycles() : clocks per line bit for a given clock and baud rate
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit, truncated; any fractional clock is dropped.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Single-clock synchronous FIFO holding bytes waiting to be serialised.
// Storage is a plain register array; the read side is fall-through, so the
// head entry is visible on rd_data whenever the FIFO is not empty.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (clears pointers only)
//   wr_en   : push wr_data (ignored when full)
//   wr_data : byte to push
//   rd_en   : pop the head entry (ignored when empty)
//   rd_data : current head entry
//   full    : no free entries
//   empty   : no stored entries
//   level   : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Payload storage needs no reset: an entry is only ever read after it has
  // been written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers move independently, so a push and a pop on the same edge
  // leave the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top
// UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first. Bytes
// are queued in a byte FIFO and sent back-to-back with no idle gap.
//   Clk     : system clock, rising edge
//   Rst     : asynchronous active-low reset
//   i_Data  : byte to transmit
//   i_Valid : i_Data valid this cycle (accepted when o_Ready is high)
//   o_Ready : FIFO can accept a byte
//   o_Tx    : registered serial line, idle high
//   o_Busy  : frame in progress or bytes still queued
//   o_Level : FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_top #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [7:0]                    i_Data,
  input  logic                          i_Valid,
  output logic                          o_Ready,
  output logic                          o_Tx,
  output logic                          o_Busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_Level
);

  import uart_pkg::*;

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int          BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t       state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              tx_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_data;
  logic              push;
  logic              pop;
  logic              bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // A full FIFO refuses writes even when the FSM pops on the same edge.
  assign o_Ready = !fifo_full;
  assign push    = i_Valid && o_Ready;

  // The FSM takes the head either from IDLE or at the end of a stop bit;
  // the latter lets the next start bit follow with no idle gap.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == STOP) && bit_end));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst),
    .wr_en   (push),
    .wr_data (i_Data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_Level)
  );

  assign o_Busy = (state != IDLE) || (o_Level != '0);
  assign o_Tx   = tx_q;

  // Serialiser FSM with baud counter, bit counter and shift register.
  // The line register follows the current state, so it lags the state by
  // one clock: a byte popped at one edge drives the start bit from the next.
  // Every state lasts the same number of clocks, so bit widths are exact.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift[0];
        default: tx_q <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= fifo_data;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= fifo_data;
              bit_cnt <= '0;
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
